// File: rtl/pipe_reg_hs_pkg.sv
// Shared types and helpers for the handshake pipeline register stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_FULL     = 2'd1,
    ST_SKIDFULL = 2'd2
  } pipe_state_t;

  localparam int OCC_W = 2;

  function automatic logic [OCC_W-1:0] occ_of(input pipe_state_t st);
    logic [OCC_W-1:0] occ;
    case (st)
      ST_EMPTY:    occ = 2'd0;
      ST_FULL:     occ = 2'd1;
      ST_SKIDFULL: occ = 2'd2;
      default:     occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_reg_hs_if.sv
// Handshake bus of one pipeline register stage: upstream side, downstream side,
// flush and occupancy.
import pipe_pkg::*;

interface pipe_reg_hs_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_reg_hs_reg.sv
// WIDTH-bit enable register with asynchronous active-low reset to RESET_VAL.
import pipe_pkg::*;

module hs_reg_arn #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Data storage, loaded only when enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_reg_hs.sv
// Handshake pipeline register stage; SKID selects a 2-entry skid buffer with a
// registered in_ready, otherwise a single entry with pass-through ready.
import pipe_pkg::*;

module pipe_reg_hs #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               SKID      = 1
) (
  input logic            clk,
  input logic            reset_n,
  pipe_reg_hs_if.slave   bus
);

  pipe_state_t      state_r;
  pipe_state_t      state_nx_s;
  logic [OCC_W-1:0] occ_r;
  logic             rdy_r;
  logic             in_ready_s;
  logic             out_valid_s;
  logic             in_fire_s;
  logic             out_fire_s;
  logic             main_en_s;
  logic             main_sel_skid_s;
  logic [WIDTH-1:0] main_d_s;
  logic [WIDTH-1:0] main_q_s;
  logic [WIDTH-1:0] skid_q_s;

  assign out_valid_s = (state_r != ST_EMPTY);
  assign in_fire_s   = bus.in_valid && in_ready_s;
  assign out_fire_s  = out_valid_s && bus.out_ready;

  // Upstream ready: skid mode looks only at registered state.
  always_comb begin
    in_ready_s = 1'b0;
    if (SKID != 0) begin
      in_ready_s = rdy_r && (state_r != ST_SKIDFULL);
    end else begin
      in_ready_s = rdy_r && (!out_valid_s || bus.out_ready);
    end
  end

  // Next-state and main-register load decode; flush overrides every transfer.
  always_comb begin
    state_nx_s      = state_r;
    main_en_s       = 1'b0;
    main_sel_skid_s = 1'b0;
    if (bus.flush) begin
      state_nx_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_nx_s = ST_FULL;
            main_en_s  = 1'b1;
          end else begin
            state_nx_s = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (in_fire_s && (out_fire_s || (SKID == 0))) begin
            main_en_s = 1'b1;
          end else if (in_fire_s) begin
            state_nx_s = ST_SKIDFULL;
          end else if (out_fire_s) begin
            state_nx_s = ST_EMPTY;
          end else begin
            state_nx_s = ST_FULL;
          end
        end
        ST_SKIDFULL: begin
          if (out_fire_s) begin
            state_nx_s      = ST_FULL;
            main_en_s       = 1'b1;
            main_sel_skid_s = 1'b1;
          end else begin
            state_nx_s = ST_SKIDFULL;
          end
        end
        default: begin
          state_nx_s = ST_EMPTY;
        end
      endcase
    end
  end

  // Control state, occupancy and the post-reset ready enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_EMPTY;
      occ_r   <= 2'd0;
      rdy_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      occ_r   <= occ_of(state_nx_s);
      rdy_r   <= 1'b1;
    end
  end

  assign main_d_s = main_sel_skid_s ? skid_q_s : bus.in_data;

  hs_reg_arn #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (main_en_s),
    .d       (main_d_s),
    .q       (main_q_s)
  );

  // The skid entry only captures when main is held by a stalled consumer.
  if (SKID != 0) begin : g_skid
    logic skid_en_s;
    assign skid_en_s = !bus.flush && (state_r == ST_FULL) && in_fire_s && !out_fire_s;
    hs_reg_arn #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (skid_en_s),
      .d       (bus.in_data),
      .q       (skid_q_s)
    );
  end else begin : g_noskid
    assign skid_q_s = RESET_VAL;
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = main_q_s;
  assign bus.occupancy = occ_r;

endmodule

// File: tb/tb_pipe_reg_hs.sv
// Scoreboard bench for pipe_reg_hs: one skid-mode and one single-entry instance.
module tb_pipe_reg_hs;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  pipe_reg_hs_if #(.WIDTH(8)) if1 ();
  pipe_reg_hs_if #(.WIDTH(8)) if0 ();

  pipe_reg_hs #(.WIDTH(8), .RESET_VAL(8'h5A), .SKID(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1)
  );
  pipe_reg_hs #(.WIDTH(8), .RESET_VAL(8'hC3), .SKID(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0)
  );

  int         tests = 0;
  int         fails = 0;
  int         max_occ0 = 0;
  logic [7:0] q1[$];
  logic [7:0] q0[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: pop the expected payload whenever a stage hands one downstream.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && if1.out_valid && if1.out_ready) begin
      if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL dut1_unexpected_out: got %0h expected nothing", if1.out_data);
      end else begin
        chk("dut1_order", 32'(if1.out_data), 32'(q1.pop_front()));
      end
    end
    if (reset_n === 1'b1 && if0.out_valid && if0.out_ready) begin
      if (q0.size() == 0) begin
        tests++; fails++;
        $display("FAIL dut0_unexpected_out: got %0h expected nothing", if0.out_data);
      end else begin
        chk("dut0_order", 32'(if0.out_data), 32'(q0.pop_front()));
      end
    end
    if (reset_n === 1'b1 && int'(if0.occupancy) > max_occ0) max_occ0 = int'(if0.occupancy);
  end

  task automatic wait_ready1(input int budget);
    int n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (if1.in_ready) break;
      n++;
    end
    chk("dut1_ready_timeout", 32'(n < budget), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    if1.flush = 1'b0; if1.in_valid = 1'b1; if1.in_data = 8'hFF; if1.out_ready = 1'b0;
    if0.flush = 1'b0; if0.in_valid = 1'b1; if0.in_data = 8'hFF; if0.out_ready = 1'b0;

    // 1. reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst1_out_valid", 32'(if1.out_valid), 32'd0);
    chk("rst1_in_ready",  32'(if1.in_ready),  32'd0);
    chk("rst1_out_data",  32'(if1.out_data),  32'h5A);
    chk("rst1_occ",       32'(if1.occupancy), 32'd0);
    chk("rst0_out_valid", 32'(if0.out_valid), 32'd0);
    chk("rst0_in_ready",  32'(if0.in_ready),  32'd0);
    chk("rst0_out_data",  32'(if0.out_data),  32'hC3);
    @(posedge clk); #1;
    reset_n = 1'b1; if1.in_valid = 1'b0; if0.in_valid = 1'b0;
    @(negedge clk);
    chk("rel1_ready_before_edge", 32'(if1.in_ready), 32'd0);
    @(negedge clk);
    chk("rel1_ready_first_edge", 32'(if1.in_ready), 32'd1);
    chk("rel0_ready_first_edge", 32'(if0.in_ready), 32'd1);

    // 2. streaming, SKID=1
    if1.out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if1.in_valid = 1'b1; if1.in_data = 8'(i); q1.push_back(8'(i));
      @(negedge clk);
      chk("stream_in_ready", 32'(if1.in_ready), 32'd1);
      if (i == 1) chk("stream_latency", 32'(if1.out_valid), 32'd0);
    end
    @(posedge clk); #1; if1.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("stream_drained", 32'(q1.size()), 32'd0);
    chk("stream_occ_end", 32'(if1.occupancy), 32'd0);

    // 3. backpressure, SKID=1
    @(posedge clk); #1;
    if1.out_ready = 1'b0; if1.in_valid = 1'b1; if1.in_data = 8'hA1; q1.push_back(8'hA1);
    @(negedge clk);
    chk("bp_ready_empty", 32'(if1.in_ready), 32'd1);
    @(posedge clk); #1; if1.in_data = 8'hA2; q1.push_back(8'hA2);
    @(negedge clk);
    chk("bp_occ1", 32'(if1.occupancy), 32'd1);
    chk("bp_ready_full", 32'(if1.in_ready), 32'd1);
    chk("bp_data_a1", 32'(if1.out_data), 32'hA1);
    @(posedge clk); #1; if1.in_data = 8'hA3; q1.push_back(8'hA3);
    @(negedge clk);
    chk("bp_occ2", 32'(if1.occupancy), 32'd2);
    chk("bp_ready_skidfull", 32'(if1.in_ready), 32'd0);
    repeat (2) @(negedge clk);
    chk("bp_occ2_hold", 32'(if1.occupancy), 32'd2);
    chk("bp_data_stable", 32'(if1.out_data), 32'hA1);
    @(posedge clk); #1; if1.out_ready = 1'b1;
    wait_ready1(5);
    @(posedge clk); #1; if1.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp_drained", 32'(q1.size()), 32'd0);
    chk("bp_occ_end", 32'(if1.occupancy), 32'd0);

    // 4. flush from SKIDFULL, then from FULL with a discarded in_fire
    @(posedge clk); #1;
    if1.out_ready = 1'b0; if1.in_valid = 1'b1; if1.in_data = 8'h11;
    @(posedge clk); #1; if1.in_data = 8'h22;
    @(posedge clk); #1; if1.in_data = 8'h33; if1.flush = 1'b1;
    @(negedge clk);
    chk("fl_occ_before", 32'(if1.occupancy), 32'd2);
    @(posedge clk); #1; if1.flush = 1'b0; if1.in_valid = 1'b0;
    @(negedge clk);
    chk("fl_out_valid", 32'(if1.out_valid), 32'd0);
    chk("fl_occ", 32'(if1.occupancy), 32'd0);
    chk("fl_ready", 32'(if1.in_ready), 32'd1);
    @(posedge clk); #1; if1.in_valid = 1'b1; if1.in_data = 8'h44;
    @(posedge clk); #1; if1.in_data = 8'h55; if1.flush = 1'b1;
    @(negedge clk);
    chk("fl2_ready", 32'(if1.in_ready), 32'd1);
    @(posedge clk); #1; if1.flush = 1'b0; if1.in_valid = 1'b0; if1.out_ready = 1'b1;
    @(negedge clk);
    chk("fl2_out_valid", 32'(if1.out_valid), 32'd0);
    chk("fl2_occ", 32'(if1.occupancy), 32'd0);
    chk("fl2_data_held", 32'(if1.out_data), 32'h44);
    repeat (3) @(negedge clk);

    // 5. SKID=0, same stimulus as backpressure
    @(posedge clk); #1;
    if0.out_ready = 1'b0; if0.in_valid = 1'b1; if0.in_data = 8'hA1; q0.push_back(8'hA1);
    @(negedge clk);
    chk("s0_ready_empty", 32'(if0.in_ready), 32'd1);
    @(posedge clk); #1; if0.in_data = 8'hA2; q0.push_back(8'hA2);
    @(negedge clk);
    chk("s0_occ1", 32'(if0.occupancy), 32'd1);
    chk("s0_ready_stalled", 32'(if0.in_ready), 32'd0);
    chk("s0_data_a1", 32'(if0.out_data), 32'hA1);
    #1; if0.out_ready = 1'b1;
    #1; chk("s0_ready_comb_hi", 32'(if0.in_ready), 32'd1);
    if0.out_ready = 1'b0;
    #1; chk("s0_ready_comb_lo", 32'(if0.in_ready), 32'd0);
    @(posedge clk); #1; if0.out_ready = 1'b1;
    @(negedge clk);
    chk("s0_ready_pass", 32'(if0.in_ready), 32'd1);
    @(posedge clk); #1; if0.in_data = 8'hA3; q0.push_back(8'hA3);
    @(negedge clk);
    chk("s0_occ_stream", 32'(if0.occupancy), 32'd1);
    @(posedge clk); #1; if0.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("s0_drained", 32'(q0.size()), 32'd0);
    chk("s0_occ_end", 32'(if0.occupancy), 32'd0);
    chk("s0_max_occ", 32'(max_occ0), 32'd1);

    // 6. async reset while SKIDFULL
    @(posedge clk); #1;
    if1.out_ready = 1'b0; if1.in_valid = 1'b1; if1.in_data = 8'h61;
    @(posedge clk); #1; if1.in_data = 8'h62;
    @(posedge clk); #1; if1.in_valid = 1'b0;
    @(negedge clk);
    chk("ar_occ_before", 32'(if1.occupancy), 32'd2);
    #2; reset_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(if1.out_valid), 32'd0);
    chk("ar_occ", 32'(if1.occupancy), 32'd0);
    chk("ar_in_ready", 32'(if1.in_ready), 32'd0);
    chk("ar_out_data", 32'(if1.out_data), 32'h5A);
    repeat (2) @(posedge clk); #1; reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("ar_recover_ready", 32'(if1.in_ready), 32'd1);
    chk("ar_q_empty", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
